demux_stream_32: RTL and testbench

DEMUX_STREAM_32 -- requirements
Module: demux_stream_32

---
 rtl/demux_pkg.sv | 14 +
 rtl/demux_lane_reg.sv | 58 +++++
 rtl/demux_stream_32.sv | 71 +++++++
 tb/tb_demux_stream_32.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// ============================================================
// demux_pkg : shared defaults and lane indices for demux_stream_32
// Revision  : 1.0
// ============================================================
`default_nettype none

package demux_pkg;
  localparam int   DEF_WIDTH = 32;
  localparam int   DEF_CNT_W = 16;
  localparam logic LANE0     = 1'b0;
  localparam logic LANE1     = 1'b1;
endpackage

`default_nettype wire

// File: rtl/demux_lane_reg.sv
// ============================================================
// demux_lane_reg : one-entry valid/ready output register with a
//                  saturating delivered-word counter
// Revision       : 1.0
// ============================================================
`default_nettype none

module demux_lane_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             can_load,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic pop;

  assign pop      = out_valid && out_ready;
  // A pop frees the slot in the same cycle, so load and pop may coincide.
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (pop && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_stream_32.sv
// ============================================================
// demux_stream_32 : 1-to-2 valid/ready stream demultiplexer with
//                   per-lane delivered-word counters
// Revision        : 1.0
// ============================================================
`default_nettype none

module demux_stream_32
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic can_load0;
  logic can_load1;
  logic accept;
  logic load0;
  logic load1;

  // Ready only reflects the lane the current word is steered to.
  assign in_ready = (in_select == LANE1) ? can_load1 : can_load0;
  assign accept   = in_valid && in_ready;
  assign load0    = accept && (in_select == LANE0);
  assign load1    = accept && (in_select == LANE1);

  demux_lane_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load0),
    .load_data (in_data),
    .can_load  (can_load0),
    .out_data  (out0_data),
    .out_valid (out0_valid),
    .out_ready (out0_ready),
    .cnt_clr   (cnt_clr),
    .cnt       (cnt0)
  );

  demux_lane_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load1),
    .load_data (in_data),
    .can_load  (can_load1),
    .out_data  (out1_data),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .cnt_clr   (cnt_clr),
    .cnt       (cnt1)
  );

endmodule

`default_nettype wire

// File: tb/tb_demux_stream_32.sv
// ============================================================
// tb_demux_stream_32 : directed self-checking bench, 4-bit counters
// Revision           : 1.0
// ============================================================
`default_nettype none

module tb_demux_stream_32;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_select;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int vectors     = 0;
  int miscompares = 0;

  demux_stream_32 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt_clr    (cnt_clr),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = $urandom;
    in_select  = 1'($urandom_range(0, 1));
    in_valid   = 1'b1;
    out0_ready = 1'($urandom_range(0, 1));
    out1_ready = 1'($urandom_range(0, 1));
    cnt_clr    = 1'($urandom_range(0, 1));
    #22;
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data",  out0_data, 32'd0);
    chk("rst_out1_data",  out1_data, 32'd0);
    chk("rst_cnt0",       32'(cnt0), 32'd0);
    chk("rst_cnt1",       32'(cnt1), 32'd0);
    chk("rst_in_ready",   32'(in_ready), 32'd1);

    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    cnt_clr    = 1'b0;
    step();
    rst_n = 1'b1;

    // Steering
    in_data = 32'hAAAA_0001; in_select = 1'b0; in_valid = 1'b1;
    #1 chk("steer_ready0", 32'(in_ready), 32'd1);
    step();
    in_data = 32'h5555_0002; in_select = 1'b1;
    chk("steer_out0_valid", 32'(out0_valid), 32'd1);
    chk("steer_out0_data",  out0_data, 32'hAAAA_0001);
    chk("steer_out1_empty", 32'(out1_valid), 32'd0);
    step();
    in_valid = 1'b0; in_data = 32'hDEAD_BEEF; in_select = 1'b0;
    chk("steer_out1_valid", 32'(out1_valid), 32'd1);
    chk("steer_out1_data",  out1_data, 32'h5555_0002);
    chk("steer_out0_drain", 32'(out0_valid), 32'd0);
    chk("steer_cnt0",       32'(cnt0), 32'd1);
    step();
    chk("steer_ignore_inv", 32'(out0_valid), 32'd0);
    chk("steer_out1_drain", 32'(out1_valid), 32'd0);
    chk("steer_cnt1",       32'(cnt1), 32'd1);

    // Backpressure on lane 0 while lane 1 flows
    out0_ready = 1'b0;
    in_data = 32'hB000_0000; in_select = 1'b0; in_valid = 1'b1;
    step();
    in_data = 32'hB000_0001;
    #1;
    chk("bp_out0_data",  out0_data, 32'hB000_0000);
    chk("bp_in_ready0",  32'(in_ready), 32'd0);
    step();
    chk("bp_hold_data",  out0_data, 32'hB000_0000);
    chk("bp_hold_valid", 32'(out0_valid), 32'd1);
    in_data = 32'hC000_0000; in_select = 1'b1;
    #1 chk("bp_in_ready1", 32'(in_ready), 32'd1);
    step();
    chk("bp_out1_data",   out1_data, 32'hC000_0000);
    chk("bp_still_held",  out0_data, 32'hB000_0000);
    in_data = 32'hB000_0001; in_select = 1'b0; out0_ready = 1'b1;
    #1 chk("bp_ready_pop", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_second_valid", 32'(out0_valid), 32'd1);
    chk("bp_second_data",  out0_data, 32'hB000_0001);
    chk("bp_cnt0",         32'(cnt0), 32'd2);
    chk("bp_cnt1",         32'(cnt1), 32'd2);
    chk("bp_out1_drain",   32'(out1_valid), 32'd0);
    step();
    chk("bp_out0_drain",   32'(out0_valid), 32'd0);
    chk("bp_cnt0_final",   32'(cnt0), 32'd3);

    // Throughput: 8 back-to-back lane-0 words
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_cnt0", 32'(cnt0), 32'd0);
    chk("clr_cnt1", 32'(cnt1), 32'd0);
    in_valid = 1'b1; in_select = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h7000_0000 + 32'(i);
      #1 chk("tp_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("tp_out0_valid", 32'(out0_valid), 32'd1);
      chk("tp_out0_data",  out0_data, 32'h7000_0000 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    chk("tp_drain", 32'(out0_valid), 32'd0);
    chk("tp_cnt0",  32'(cnt0), 32'd8);

    // Counter saturation on lane 1
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    in_valid = 1'b1; in_select = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 32'h1100_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("sat_cnt1", 32'(cnt1), 32'd15);
    chk("sat_cnt0", 32'(cnt0), 32'd0);
    in_data = 32'h1200_0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0; cnt_clr = 1'b1;
    chk("clrhs_valid", 32'(out1_valid), 32'd1);
    step();
    cnt_clr = 1'b0;
    chk("clrhs_cnt1", 32'(cnt1), 32'd0);

    // Mid-operation reset with both lanes full and stalled
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_data = 32'hD000_0000; in_select = 1'b0; in_valid = 1'b1;
    step();
    in_data = 32'hD000_0001; in_select = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mr_full0", 32'(out0_valid), 32'd1);
    chk("mr_full1", 32'(out1_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid0", 32'(out0_valid), 32'd0);
    chk("mr_valid1", 32'(out1_valid), 32'd0);
    chk("mr_data0",  out0_data, 32'd0);
    chk("mr_data1",  out1_data, 32'd0);
    out0_ready = 1'b1; out1_ready = 1'b1;
    step();
    step();
    chk("mr_cnt0",  32'(cnt0), 32'd0);
    chk("mr_cnt1",  32'(cnt1), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    in_data = 32'hE000_0000; in_select = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("resume_valid", 32'(out0_valid), 32'd1);
    chk("resume_data",  out0_data, 32'hE000_0000);
    step();
    chk("resume_cnt0",  32'(cnt0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
